spi_mult_master: RTL and testbench

SPI controller that drives the multiplier peripheral from the host side, acting as the initiator of the link that the peripheral answers.
- Accepts two WIDTH-bit operands on a start handshake.
- Asserts cs and generates sclk from the system clock.
- Shifts operand A then operand B out on mosi, MSB first.
- Keeps sclk running while the peripheral multiplies.
- Clocks the 2*WIDTH-bit product back in on miso and presents it with a one-cycle done pulse.

---
 rtl/spi_mult_master.sv | 172 +++++++++++++++++
 tb/tb_spi_mult_master.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_mult_master.sv
// spi_mult_master: host-side SPI initiator for the serial multiplier peripheral.
//
// A start handshake (accepted only while idle) captures two WIDTH-bit operands.
// The block raises cs, shifts {op_a, op_b} out on mosi MSB first, and keeps
// sclk running for MULT_WAIT full periods while the peripheral multiplies. It
// then clocks the 2*WIDTH-bit product back in on miso, MSB first. The product
// appears on result together with a one-cycle done pulse.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   start, op_a, op_b request and operands (captured on accept)
//   busy, done        transfer in progress / one-cycle completion pulse
//   result            last received product, held until the next done
//   cs, sclk, mosi    SPI outputs (cs active high, sclk idles low)
//   miso              SPI input, sampled only while receiving
//   check_err         only with MULT_CHECK_EN: received product != op_a*op_b
//
// Optional feature macro: MULT_CHECK_EN
module spi_mult_master #(
  parameter int WIDTH     = 8,
  parameter int CLKDIV    = 2,
  parameter int MULT_WAIT = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               cs,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso
`ifdef MULT_CHECK_EN
  ,
  output logic               check_err
`endif
);
  localparam int PW = 2*WIDTH;
  localparam int TW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = $clog2(PW) + 1;
  localparam int WW = (MULT_WAIT > 0) ? $clog2(2*MULT_WAIT + 1) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT, RECV, HOLD} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [BW-1:0] bit_cnt;
  logic [WW-1:0] wait_cnt;
  logic [PW-1:0] tx_sr;
  logic [PW-1:0] rx_sr;
  logic          last_bit;
  logic          last_wait;
`ifdef MULT_CHECK_EN
  logic [PW-1:0] exp_q;
`endif

  // Each tick is one sclk half-period boundary.
  assign tick      = (state_q != IDLE) && (tick_cnt == TW'(CLKDIV-1));
  assign last_bit  = (bit_cnt == BW'(PW-1));
  assign last_wait = (wait_cnt == WW'(2*MULT_WAIT-1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; bit phases end on the falling tick (sclk currently high).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (tick) state_d = SEND;
      SEND:    if (tick && sclk && last_bit) state_d = (MULT_WAIT == 0) ? RECV : WAIT;
      WAIT:    if (tick && last_wait) state_d = RECV;
      RECV:    if (tick && sclk && last_bit) state_d = HOLD;
      HOLD:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decoded outputs
  always_comb begin
    busy = (state_q != IDLE);
    cs   = (state_q == SETUP) || (state_q == SEND) ||
           (state_q == WAIT)  || (state_q == RECV);
  end

  // Tick divider, serial clock, shift registers and result
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
`ifdef MULT_CHECK_EN
      check_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state_q == IDLE || tick) tick_cnt <= '0;
      else                         tick_cnt <= tick_cnt + TW'(1);

      case (state_q)
        IDLE: begin
          if (start) begin
            tx_sr   <= {op_a, op_b};
            mosi    <= op_a[WIDTH-1];
            bit_cnt <= '0;
            sclk    <= 1'b0;
`ifdef MULT_CHECK_EN
            exp_q   <= op_a * op_b;
`endif
          end
        end
        SEND: begin
          if (tick) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (last_bit) begin
                mosi     <= 1'b0;
                bit_cnt  <= '0;
                wait_cnt <= '0;
              end else begin
                tx_sr   <= tx_sr << 1;
                mosi    <= tx_sr[PW-2];
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
        end
        WAIT: begin
          if (tick) begin
            sclk     <= ~sclk;
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        RECV: begin
          if (tick) begin
            if (!sclk) begin
              sclk  <= 1'b1;
              rx_sr <= {rx_sr[PW-2:0], miso};
            end else begin
              sclk    <= 1'b0;
              bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
            end
          end
        end
        HOLD: begin
          if (tick) begin
            result    <= rx_sr;
            done      <= 1'b1;
`ifdef MULT_CHECK_EN
            check_err <= (rx_sr != exp_q);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mult_master.sv
// Testbench for spi_mult_master: a peripheral model answers the link with the
// product of the operands it decoded from mosi, and results, latency, cs width
// and mosi bit order are compared against values computed here.
module tb_spi_mult_master;
  localparam int W    = 8;
  localparam int CD   = 2;
  localparam int MW   = 10;
  localparam int PW   = 2*W;
  localparam int LAT  = (2 + 8*W + 2*MW)*CD;
  localparam int CSHI = LAT - CD;

  logic          clk, reset, start, miso;
  logic [W-1:0]  op_a, op_b;
  logic          busy, done, cs, sclk, mosi;
  logic [PW-1:0] result;
`ifdef MULT_CHECK_EN
  logic          check_err;
`endif

  spi_mult_master #(.WIDTH(W), .CLKDIV(CD), .MULT_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .cs(cs), .sclk(sclk),
    .mosi(mosi), .miso(miso)
`ifdef MULT_CHECK_EN
    , .check_err(check_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Peripheral model: samples mosi on sclk rising edges, and after the
  // (2W+MW)-th falling edge shifts out its reply MSB first on falling edges.
  logic [PW-1:0] mosi_bits;
  logic [PW-1:0] reply;
  bit            corrupt;
  initial begin
    automatic logic prev_sclk = 1'b0;
    automatic int   rises = 0;
    automatic int   falls = 0;
    miso = 1'b0;
    mosi_bits = '0;
    reply = '0;
    forever begin
      @(posedge clk); #1;
      if (!cs) begin
        rises = 0;
        falls = 0;
        miso  = 1'b0;
      end else begin
        if (sclk && !prev_sclk) begin
          if (rises < PW) mosi_bits = {mosi_bits[PW-2:0], mosi};
          rises++;
        end
        if (!sclk && prev_sclk) begin
          falls++;
          if (falls >= PW + MW && falls < 2*PW + MW) begin
            if (falls == PW + MW)
              reply = corrupt ? PW'(1) : PW'(mosi_bits[PW-1:W]) * PW'(mosi_bits[W-1:0]);
            miso = reply[2*PW + MW - 1 - falls];
          end
        end
      end
      prev_sclk = sclk;
    end
  end

  task automatic do_xfer(input logic [W-1:0] a, input logic [W-1:0] b, input bit crpt,
                         input int poke_at, output logic [PW-1:0] res, output int lat,
                         output int cs_hi, output logic busy_poke);
    corrupt = crpt;
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_on_accept", busy, 1);
    lat = 0; cs_hi = 0; busy_poke = 1'b1;
    while (!done && lat < 2*LAT) begin
      if (cs) cs_hi++;
      if (lat == poke_at) begin start = 1'b1; op_a = 8'hFF; end
      if (lat == poke_at + 1) begin start = 1'b0; busy_poke = busy; end
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [PW-1:0] exp, input int poke_at);
    logic [PW-1:0] res;
    int            lat, cs_hi;
    logic          bp;
    do_xfer(a, b, 1'b0, poke_at, res, lat, cs_hi, bp);
    chk({tag, "_result"}, res, exp);
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_cs_high"}, cs_hi, CSHI);
    chk({tag, "_mosi_bits"}, mosi_bits, {a, b});
`ifdef MULT_CHECK_EN
    chk({tag, "_check_err"}, check_err, 0);
`endif
    if (poke_at >= 0) chk({tag, "_busy_at_poke"}, bp, 1);
  endtask

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] exp;
  } vec_t;

  initial begin
    vec_t          vecs[6];
    logic [PW-1:0] res;
    int            lat, cs_hi, cyc;
    logic          bp;
    logic [W-1:0]  ra, rb;

    vecs[0] = '{8'hA5, 8'h3C, 16'h26AC};
    vecs[1] = '{8'h02, 8'h03, 16'h0006};
    vecs[2] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[3] = '{8'h00, 8'h07, 16'h0000};
    vecs[4] = '{8'h80, 8'h80, 16'h4000};
    vecs[5] = '{8'h01, 8'hFF, 16'h00FF};

    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; corrupt = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset: everything quiet.
    for (int i = 0; i < 20; i++) begin
      chk("idle_quiet", {cs, sclk, mosi, busy, done, result}, 0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 6; i++) run_check("vec", vecs[i].a, vecs[i].b, vecs[i].exp, -1);

    // start pulsed mid-transfer with op_a=FF must be ignored.
    run_check("ignored_start", 8'hA5, 8'h3C, 16'h26AC, 50);

    // Reset in the middle of SEND abandons the transfer.
    op_a = 8'h55; op_b = 8'hAA; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_outputs", {cs, sclk, mosi, busy, done}, 0);
    chk("midreset_result", result, 0);
    reset = 1'b0;
    run_check("after_reset", 8'h02, 8'h03, 16'h0006, -1);

    // Back-to-back with start held high.
    corrupt = 1'b0;
    op_a = 8'hFF; op_b = 8'hFF; start = 1'b1;
    cyc = 0;
    while (!done && cyc < 2*LAT) begin @(posedge clk); #1; cyc++; end
    chk("b2b_first_latency", cyc, LAT + 1);
    chk("b2b_first_result", result, 16'hFE01);
    chk("b2b_hold_sclk_cs", {sclk, cs}, 0);
    op_a = 8'h00; op_b = 8'h07;
    cyc = 0;
    @(posedge clk); #1; cyc++;
    chk("b2b_done_pulse", done, 0);
    chk("b2b_second_accept", busy, 1);
    while (!done && cyc < 2*LAT) begin @(posedge clk); #1; cyc++; end
    chk("b2b_second_latency", cyc, LAT + 1);
    chk("b2b_second_result", result, 16'h0000);
    chk("b2b_second_mosi", mosi_bits, 16'h0007);
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_idle", {done, busy}, 0);

    // Randomized transfers against a plain-arithmetic product.
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      run_check("rand", ra, rb, PW'(ra) * PW'(rb), -1);
    end

`ifdef MULT_CHECK_EN
    do_xfer(8'h10, 8'h10, 1'b1, -1, res, lat, cs_hi, bp);
    chk("chk_bad_result", res, 16'h0001);
    chk("chk_err_set", check_err, 1);
    do_xfer(8'h10, 8'h10, 1'b0, -1, res, lat, cs_hi, bp);
    chk("chk_good_result", res, 16'h0100);
    chk("chk_err_clear", check_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
